data_mem_bus: RTL and testbench
===============================

# data_mem_bus

MEM-stage data memory and peripheral bus for the pipelined CPU. Consumes the EX/MEM register outputs (read/write strobes, ALU result as byte address, store data) and returns load data combinationally for capture by the MEM/WB register. Decodes the address into word RAM plus memory-mapped peripherals: timer with interrupt, LEDs, 7-segment digits and a free-running systick.

## Interface
- RAM_DEPTH, 256, data RAM size in 32-bit words (power of two, at most 256).
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- MemRead  in  1  load strobe from the EX/MEM register.
- MemWrite  in  1  store strobe from the EX/MEM register.
- Addr  in  32  byte address (EX/MEM ALU result).
- WriteData  in  32  store data.
- ReadData  out  32  load data, combinational.
- leds  out  8  LED register.
- digits  out  12  7-segment register: [11:8] anode select, [7:0] segments.
- irq  out  1  timer interrupt request, equal to TCON[2].

## Operation
- Addr[1:0] is ignored; all accesses are whole words.
- Address map:
  - RAM: 0x0000_0000 up to RAM_DEPTH*4-1, word index Addr[9:2].
  - TH: 0x4000_0000, read/write, 32 bits.
  - TL: 0x4000_0004, read/write, 32 bits.
  - TCON: 0x4000_0008, read/write, bits [2:0]; bit0 = enable, bit1 = interrupt enable, bit2 = interrupt status; upper bits read 0.
  - leds: 0x4000_000C, read/write, bits [7:0].
  - digits: 0x4000_0010, read/write, bits [11:0].
  - systick: 0x4000_0014, read-only; writes are ignored.
- Unmapped addresses read 0; writes to them are ignored.
- ReadData is 0 whenever MemRead=0.
- MemRead and MemWrite both high is a legal case: the read returns the old value and the write commits at the clock edge.
- Timer, every cycle with TCON[0]=1:
  - If TL==0xFFFF_FFFF, TL<=TH, and if TCON[1]=1 then TCON[2]<=1.
  - Otherwise TL<=TL+1.
  - TCON[2] is sticky; only a CPU write to TCON clears it.
- Systick increments by 1 every cycle and wraps from 0xFFFF_FFFF to 0.
- Collisions: a CPU write to TL or TCON in the same cycle as a timer update wins outright; the timer update is dropped for that cycle.

## Timing
- Loads have zero-cycle latency: ReadData is a combinational function of Addr, MemRead and the current state.
- Stores take effect at the rising edge where MemWrite=1; a load in the next cycle sees the new value.
- Reset value of every output and register is 0: TH, TL, TCON, leds, digits, systick, ReadData (with MemRead=0), irq.
- RAM contents are not cleared by reset.
- Reset asserted mid-count clears the timer and systick immediately, without waiting for a clock edge. Counting resumes on the first edge after reset deasserts (reset=1).
- irq rises in the cycle after the TL wrap edge.

## Configuration
- DATA_MEM_BUS_TIMER_EN defined: TH, TL and TCON are implemented as described, and irq = TCON[2].
- DATA_MEM_BUS_TIMER_EN undefined: no timer registers exist; addresses 0x4000_0000 to 0x4000_0008 read 0 and ignore writes; irq is tied to 0. RAM, leds, digits and systick are unchanged.

## Test plan
- RAM store/load: write 0xDEAD_BEEF to 0x0000_0010, then read 0x0000_0010 -> 0xDEAD_BEEF; read 0x0000_0013 -> same value (low address bits ignored); read 0x0000_0400 -> 0.
- Timer wrap: TH=0xFFFF_FFF0, TL=0xFFFF_FFFE, TCON=3 -> TL reads 0xFFFF_FFFF after 1 cycle and 0xFFFF_FFF0 after 2 cycles; irq=1 from the cycle after the wrap edge; writing TCON=3 clears irq.
- Collision: timer running, CPU writes TL=5 on a counting edge -> TL reads 5 next cycle, then 6.
- Peripherals: write leds=0x1A5 -> leds=0xA5; write digits=0x7FF -> digits=0x7FF; systick reads 2 higher on a read two cycles later; a write to systick is ignored.
- Async reset: assert reset=0 mid-count, between clock edges -> TL, TCON, leds, digits, systick and irq are 0 immediately; RAM data written earlier still reads back correctly.
- Build without DATA_MEM_BUS_TIMER_EN: write TCON=3 and TL=0xFFFF_FFFF -> reads return 0 and irq stays 0 for 10 cycles.

Source files
------------

// File: rtl/data_mem_bus.sv
// rtl/data_mem_bus.sv - MEM-stage word RAM plus memory-mapped timer, LEDs, 7-segment and systick
// Timer registers (TH/TL/TCON) and irq exist only when DATA_MEM_BUS_TIMER_EN is defined.
module data_mem_bus #(
  parameter int RAM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  leds,
  output logic [11:0] digits,
  output logic        irq
);

  localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  // Peripheral word addresses (byte address >> 2), base 0x4000_0000
  localparam logic [29:0] W_TH      = 30'h1000_0000;
  localparam logic [29:0] W_TL      = 30'h1000_0001;
  localparam logic [29:0] W_TCON    = 30'h1000_0002;
  localparam logic [29:0] W_LEDS    = 30'h1000_0003;
  localparam logic [29:0] W_DIGITS  = 30'h1000_0004;
  localparam logic [29:0] W_SYSTICK = 30'h1000_0005;

  logic [29:0]   word_addr;
  logic          unused_addr_lsbs;
  logic          ram_hit;
  logic [AW-1:0] ram_idx;
  logic          sel_leds;
  logic          sel_digits;
  logic          sel_systick;
  logic [31:0]   systick;
  logic [31:0]   timer_rdata;

  assign word_addr        = Addr[31:2];
  assign unused_addr_lsbs = ^Addr[1:0];
  assign ram_hit          = word_addr < 30'(RAM_DEPTH);
  assign ram_idx          = word_addr[AW-1:0];
  assign sel_leds         = (word_addr == W_LEDS);
  assign sel_digits       = (word_addr == W_DIGITS);
  assign sel_systick      = (word_addr == W_SYSTICK);

  // RAM is deliberately outside the reset domain so its contents survive reset
  logic [31:0] mem [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (MemWrite && ram_hit) begin
      mem[ram_idx] <= WriteData;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      leds    <= '0;
      digits  <= '0;
      systick <= '0;
    end else begin
      systick <= systick + 32'd1;
      if (MemWrite && sel_leds) begin
        leds <= WriteData[7:0];
      end
      if (MemWrite && sel_digits) begin
        digits <= WriteData[11:0];
      end
    end
  end

`ifdef DATA_MEM_BUS_TIMER_EN
  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;
  logic        sel_th;
  logic        sel_tl;
  logic        sel_tcon;
  logic        cpu_owns_timer;

  assign sel_th         = (word_addr == W_TH);
  assign sel_tl         = (word_addr == W_TL);
  assign sel_tcon       = (word_addr == W_TCON);
  // A CPU write to TL or TCON suppresses the whole timer update for that edge
  assign cpu_owns_timer = MemWrite && (sel_tl || sel_tcon);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th   <= '0;
      tl   <= '0;
      tcon <= '0;
    end else begin
      if (MemWrite && sel_th) begin
        th <= WriteData;
      end
      if (cpu_owns_timer) begin
        if (sel_tl) begin
          tl <= WriteData;
        end
        if (sel_tcon) begin
          tcon <= WriteData[2:0];
        end
      end else if (tcon[0]) begin
        if (tl == 32'hFFFF_FFFF) begin
          tl <= th;
          if (tcon[1]) begin
            tcon[2] <= 1'b1;
          end
        end else begin
          tl <= tl + 32'd1;
        end
      end
    end
  end

  always_comb begin
    timer_rdata = '0;
    if (sel_th) begin
      timer_rdata = th;
    end else if (sel_tl) begin
      timer_rdata = tl;
    end else if (sel_tcon) begin
      timer_rdata = {29'd0, tcon};
    end
  end

  assign irq = tcon[2];
`else
  assign timer_rdata = '0;
  assign irq         = 1'b0;
`endif

  // Unmapped addresses fall through to timer_rdata, which is zero outside TH/TL/TCON
  always_comb begin
    ReadData = '0;
    if (MemRead) begin
      if (ram_hit) begin
        ReadData = mem[ram_idx];
      end else if (sel_leds) begin
        ReadData = {24'd0, leds};
      end else if (sel_digits) begin
        ReadData = {20'd0, digits};
      end else if (sel_systick) begin
        ReadData = systick;
      end else begin
        ReadData = timer_rdata;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_bus.sv
// tb/tb_data_mem_bus.sv - randomized self-checking bench for data_mem_bus against a register-level model
module tb_data_mem_bus;

  localparam int RAM_DEPTH = 256;
`ifdef DATA_MEM_BUS_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  localparam logic [31:0] A_TH      = 32'h4000_0000;
  localparam logic [31:0] A_TL      = 32'h4000_0004;
  localparam logic [31:0] A_TCON    = 32'h4000_0008;
  localparam logic [31:0] A_LEDS    = 32'h4000_000C;
  localparam logic [31:0] A_DIGITS  = 32'h4000_0010;
  localparam logic [31:0] A_SYSTICK = 32'h4000_0014;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Addr = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic [7:0]  leds;
  logic [11:0] digits;
  logic        irq;

  int n_cmp = 0;
  int n_fail = 0;

  data_mem_bus #(.RAM_DEPTH(RAM_DEPTH)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Addr(Addr), .WriteData(WriteData), .ReadData(ReadData),
    .leds(leds), .digits(digits), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: the architectural registers, updated once per clock edge
  logic [31:0] m_ram    [RAM_DEPTH];
  bit          m_ram_ok [RAM_DEPTH];
  logic [31:0] m_th, m_tl, m_systick;
  logic [2:0]  m_tcon;
  logic [7:0]  m_leds;
  logic [11:0] m_digits;
  logic [31:0] a_w;

  assign a_w = {Addr[31:2], 2'b00};

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_th <= '0; m_tl <= '0; m_tcon <= '0;
      m_leds <= '0; m_digits <= '0; m_systick <= '0;
    end else begin
      m_systick <= m_systick + 32'd1;
      if (MemWrite && a_w < RAM_DEPTH * 4) begin
        m_ram[a_w[9:2]]    <= WriteData;
        m_ram_ok[a_w[9:2]] <= 1'b1;
      end
      if (MemWrite && a_w == A_LEDS) m_leds <= WriteData[7:0];
      if (MemWrite && a_w == A_DIGITS) m_digits <= WriteData[11:0];
      if (TIMER_EN) begin
        if (MemWrite && a_w == A_TH) m_th <= WriteData;
        if (MemWrite && a_w == A_TL) m_tl <= WriteData;
        else if (MemWrite && a_w == A_TCON) m_tcon <= WriteData[2:0];
        else if (m_tcon[0]) begin
          m_tl <= (m_tl == 32'hFFFF_FFFF) ? m_th : m_tl + 32'd1;
          if (m_tl == 32'hFFFF_FFFF && m_tcon[1]) m_tcon[2] <= 1'b1;
        end
      end
    end
  end

  // {known, value} that a load of this address should return
  function automatic logic [32:0] model_read(input logic [31:0] addr);
    logic [31:0] a;
    a = {addr[31:2], 2'b00};
    if (a < RAM_DEPTH * 4) return {m_ram_ok[a[9:2]], m_ram[a[9:2]]};
    case (a)
      A_TH:      return {1'b1, TIMER_EN ? m_th : 32'd0};
      A_TL:      return {1'b1, TIMER_EN ? m_tl : 32'd0};
      A_TCON:    return {1'b1, TIMER_EN ? {29'd0, m_tcon} : 32'd0};
      A_LEDS:    return {1'b1, 24'd0, m_leds};
      A_DIGITS:  return {1'b1, 20'd0, m_digits};
      A_SYSTICK: return {1'b1, m_systick};
      default:   return {1'b1, 32'd0};
    endcase
  endfunction

  task automatic op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    MemRead = rd; MemWrite = wr; Addr = a; WriteData = d;
    #1;
  endtask

  task automatic test_reset();
    #3 reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (leds !== 8'd0) begin n_fail++; $display("FAIL reset_leds: got %h expected 00", leds); end
    n_cmp++; if (digits !== 12'd0) begin n_fail++; $display("FAIL reset_digits: got %h expected 000", digits); end
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
    n_cmp++; if (ReadData !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", ReadData); end
    MemRead = 1'b1; Addr = A_SYSTICK; #1;
    n_cmp++; if (ReadData !== 32'd0) begin n_fail++; $display("FAIL reset_systick: got %h expected 0", ReadData); end
    @(negedge clk) reset = 1'b1;
    op(1, 0, A_SYSTICK, 0);
    n_cmp++; if (ReadData !== 32'd1) begin n_fail++; $display("FAIL systick_first: got %h expected 1", ReadData); end
  endtask

  task automatic test_ram();
    op(0, 1, 32'h10, 32'hDEAD_BEEF);
    op(1, 0, 32'h10, 0);
    n_cmp++; if (ReadData !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_load: got %h expected deadbeef", ReadData); end
    op(1, 0, 32'h13, 0);
    n_cmp++; if (ReadData !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_lsbs: got %h expected deadbeef", ReadData); end
    op(1, 0, 32'h400, 0);
    n_cmp++; if (ReadData !== 32'd0) begin n_fail++; $display("FAIL ram_oob: got %h expected 0", ReadData); end
    op(0, 0, 32'h10, 0);
    n_cmp++; if (ReadData !== 32'd0) begin n_fail++; $display("FAIL no_read_zero: got %h expected 0", ReadData); end
  endtask

  task automatic test_peripherals();
    logic [31:0] s1;
    op(0, 1, A_LEDS, 32'h1A5);
    op(0, 1, A_DIGITS, 32'h7FF);
    n_cmp++; if (leds !== 8'hA5) begin n_fail++; $display("FAIL leds_port: got %h expected a5", leds); end
    op(1, 0, A_LEDS, 0);
    n_cmp++; if (digits !== 12'h7FF) begin n_fail++; $display("FAIL digits_port: got %h expected 7ff", digits); end
    n_cmp++; if (ReadData !== 32'hA5) begin n_fail++; $display("FAIL leds_read: got %h expected a5", ReadData); end
    op(1, 0, A_SYSTICK, 0);
    s1 = m_systick;
    n_cmp++; if (ReadData !== s1) begin n_fail++; $display("FAIL systick_read: got %h expected %h", ReadData, s1); end
    op(0, 1, A_SYSTICK, 32'h1234_5678);
    op(1, 0, A_SYSTICK, 0);
    n_cmp++; if (ReadData !== s1 + 32'd2) begin n_fail++; $display("FAIL systick_plus2: got %h expected %h", ReadData, s1 + 32'd2); end
  endtask

  task automatic test_timer_wrap();
    logic [31:0] exp_tl [4];
    exp_tl = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'hFFFF_FFF1};
    op(0, 1, A_TH, 32'hFFFF_FFF0);
    op(0, 1, A_TL, 32'hFFFF_FFFE);
    op(0, 1, A_TCON, 32'd3);
    for (int i = 0; i < 4; i++) begin
      op(1, 0, A_TL, 0);
      n_cmp++;
      if (ReadData !== (TIMER_EN ? exp_tl[i] : 32'd0)) begin
        n_fail++; $display("FAIL timer_tl_%0d: got %h expected %h", i, ReadData, TIMER_EN ? exp_tl[i] : 32'd0);
      end
      n_cmp++;
      if (irq !== (TIMER_EN && i >= 2)) begin
        n_fail++; $display("FAIL timer_irq_%0d: got %b expected %b", i, irq, TIMER_EN && i >= 2);
      end
    end
    op(0, 1, A_TCON, 32'd3);
    op(1, 0, A_TCON, 0);
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b expected 0", irq); end
    n_cmp++; if (ReadData !== (TIMER_EN ? 32'd3 : 32'd0)) begin n_fail++; $display("FAIL tcon_read: got %h expected %h", ReadData, TIMER_EN ? 32'd3 : 32'd0); end
  endtask

  task automatic test_collision();
    op(0, 1, A_TH, 32'd0);
    op(0, 1, A_TL, 32'd100);
    op(0, 1, A_TCON, 32'd1);
    op(0, 0, 0, 0);
    op(0, 1, A_TL, 32'd5);
    op(1, 0, A_TL, 0);
    n_cmp++; if (ReadData !== (TIMER_EN ? 32'd5 : 32'd0)) begin n_fail++; $display("FAIL collision_tl: got %h expected %h", ReadData, TIMER_EN ? 32'd5 : 32'd0); end
    op(1, 0, A_TL, 0);
    n_cmp++; if (ReadData !== (TIMER_EN ? 32'd6 : 32'd0)) begin n_fail++; $display("FAIL collision_next: got %h expected %h", ReadData, TIMER_EN ? 32'd6 : 32'd0); end
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic [32:0] e;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 4))
        0, 1: a = 32'h40 + 4 * $urandom_range(0, 31) + $urandom_range(0, 3);
        2, 3: a = 32'h4000_0000 + 4 * $urandom_range(0, 6);
        default: a = ($urandom_range(0, 1) != 0) ? 32'h400 + 4 * $urandom_range(0, 15) : $urandom;
      endcase
      d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + $urandom_range(0, 7) : $urandom;
      if (a == A_TCON && $urandom_range(0, 1) != 0) d = {29'd0, 3'($urandom_range(1, 3))};
      op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d);
      e = model_read(a);
      if (e[32]) begin
        n_cmp++;
        if (ReadData !== (MemRead ? e[31:0] : 32'd0)) begin
          n_fail++; $display("FAIL rand_rdata[%0d]: addr %h got %h expected %h", i, a, ReadData, MemRead ? e[31:0] : 32'd0);
        end
      end
      n_cmp++;
      if (leds !== m_leds || digits !== m_digits || irq !== (TIMER_EN & m_tcon[2])) begin
        n_fail++; $display("FAIL rand_ports[%0d]: got %h/%h/%b expected %h/%h/%b", i, leds, digits, irq, m_leds, m_digits, TIMER_EN & m_tcon[2]);
      end
    end
  endtask

  task automatic test_async_reset();
    op(0, 1, A_TH, 32'd0);
    op(0, 1, A_TCON, 32'd3);
    op(0, 1, A_LEDS, 32'h3C);
    op(0, 1, A_DIGITS, 32'h123);
    op(0, 0, 0, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (leds !== 8'd0 || digits !== 12'd0 || irq !== 1'b0) begin n_fail++; $display("FAIL areset_ports: got %h/%h/%b expected 00/000/0", leds, digits, irq); end
    MemRead = 1'b1;
    Addr = A_TL; #1;
    n_cmp++; if (ReadData !== 32'd0) begin n_fail++; $display("FAIL areset_tl: got %h expected 0", ReadData); end
    Addr = A_TCON; #1;
    n_cmp++; if (ReadData !== 32'd0) begin n_fail++; $display("FAIL areset_tcon: got %h expected 0", ReadData); end
    Addr = A_SYSTICK; #1;
    n_cmp++; if (ReadData !== 32'd0) begin n_fail++; $display("FAIL areset_systick: got %h expected 0", ReadData); end
    @(negedge clk) reset = 1'b1;
    op(1, 0, 32'h10, 0);
    n_cmp++; if (ReadData !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL areset_ram: got %h expected deadbeef", ReadData); end
    op(1, 0, A_SYSTICK, 0);
    n_cmp++; if (ReadData !== 32'd2) begin n_fail++; $display("FAIL areset_resume: got %h expected 2", ReadData); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_peripherals();
    test_timer_wrap();
    test_collision();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
